tone_arbiter: RTL and testbench
===============================

# tone_arbiter

- Shares the single tone synthesiser (sine lookup + PWM stage) between two note sources: the live keyboard decode and the active song player.
- Arbitrates by priority and enforces a minimum note-on time so PS/2 jitter cannot chop notes.
- Inserts a silent gap between consecutive notes so back-to-back notes re-articulate.
- Sits between the note sources and the synthesiser's 5-bit note input.

## Interface
Parameters:
- GAP_CYCLES, 500000 — silent cycles between notes (10 ms at 50 MHz); ≥1.
- MIN_PLAY_CYCLES, 2500000 — minimum cycles a started note sounds; ≥1.

Ports (one clock; reset is asynchronous and active-high):
- inclk  in  1  system clock; all inputs synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- live_note  in  5  keyboard note code; 0..20 valid, anything else = no request.
- song_note  in  5  song player note code, same encoding.
- song_active  in  1  a song player is enabled; song_note ignored when 0.
- channel_sel  in  1  1 = live has priority, 0 = song has priority.
- mute  in  1  force silence.
- tone_note  out  5  to synthesiser; 21 = silence.
- owner  out  2  0 none, 1 live, 2 song.
- note_strobe  out  1  one-cycle pulse when a note starts sounding.
- busy  out  1  high in PLAY or GAP.

## Operation
- All inputs registered once (r_live, r_song, r_act, r_sel, r_mute); the FSM uses the registered copies only.
- Request validity:
  - live_req = r_live ≤ 20.
  - song_req = r_act & (r_song ≤ 20).
- Winner: the preferred source (per r_sel) if its request is valid, else the other source if valid, else none.
- Winner note: the winner's code.
- State machine:
  - IDLE: tone_note = 21, owner = 0. If a winner exists: latch its note and owner, load the counter with MIN_PLAY_CYCLES-1, pulse note_strobe, go to PLAY.
  - PLAY: tone_note = latched note. The counter decrements to 0 and holds there; while it is nonzero, input changes are ignored. At 0: if winner == owner and its note == latched note, stay; otherwise (different note, different winner, or none) load GAP_CYCLES-1 and go to GAP.
  - GAP: tone_note = 21, owner = 0. The counter decrements; at 0, go to IDLE. IDLE re-arbitrates on the following cycle.
- mute: when r_mute = 1 in any state, next state is IDLE, the counter clears, and no strobe fires. While muted, IDLE does not start notes.
- Invalid codes 22..31 are treated exactly like 21.
- The counter is a single shared down-counter, width $clog2(max(GAP_CYCLES, MIN_PLAY_CYCLES)+1).

## Timing
- Reset values: tone_note = 21, owner = 0, note_strobe = 0, busy = 0, state = IDLE, counter = 0, input registers = 21 / 0.
- All outputs are registered.
- Latency: input change at edge N is captured at N; the IDLE→PLAY decision takes effect at N+1. tone_note, owner and note_strobe update together after N+1 (2-cycle latency).
- A note lasts ≥ MIN_PLAY_CYCLES cycles.
- Successive notes are separated by exactly GAP_CYCLES cycles of 21, plus 1 IDLE cycle.
- Simultaneous valid requests: priority per r_sel, sampled at the arbitration cycle.
- r_sel changes during PLAY take effect only at the next PLAY-end check or in IDLE.
- Same note held continuously: one strobe only, with no gap.
- Reset asserted mid-note: tone_note = 21 immediately (asynchronous).

## Structure
- Shared package piano_pkg holds:
  - NOTE_REST = 5'd21 and NOTE_MAX = 5'd20.
  - OWNER_NONE / OWNER_LIVE / OWNER_SONG encodings.
  - State enum {IDLE, PLAY, GAP}.
- No sub-module: one FSM, one counter and the input registers, all in tone_arbiter.

## Test plan
Bench uses GAP_CYCLES = 4, MIN_PLAY_CYCLES = 8.
- Reset, live_note = 7, sel = 1 → 2 cycles later tone_note = 7, owner = 1, one strobe. Hold 20 cycles → no further strobe.
- live 7 for 3 cycles then 21 → tone_note = 7 for exactly 8 cycles, then 21. busy is high for 8 + 4 cycles.
- live 7 → 9 after 10 cycles → 7 until the check, 4 cycles of 21, 1 IDLE cycle, then 9 with a new strobe.
- sel = 0, song_active = 1, song_note = 14, live_note = 3 simultaneously → owner = 2, tone = 14. Drop song_active → after min time, gap, then owner = 1, tone = 3.
- mute pulse during PLAY of note 12 → tone_note = 21 within 2 cycles, state IDLE, no strobe while muted. Resumes with a strobe after mute clears.
- live_note = 25 (invalid) with song inactive → tone_note stays 21, busy stays 0. Assert reset mid-PLAY → all outputs at reset values at once.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg: note codes, owner encodings and arbiter state shared across the piano design
package piano_pkg;
    localparam logic [4:0] NOTE_REST = 5'd21;
    localparam logic [4:0] NOTE_MAX  = 5'd20;
    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_LIVE = 2'd1;
    localparam logic [1:0] OWNER_SONG = 2'd2;
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
endpackage

// File: rtl/tone_arbiter.sv
// tone_arbiter: shares the tone synthesiser between keyboard and song player,
// holding each note a minimum time and separating notes with a silent gap
module tone_arbiter
    import piano_pkg::*;
#(
    parameter int GAP_CYCLES      = 500000,
    parameter int MIN_PLAY_CYCLES = 2500000
) (
    input  logic       inclk,
    input  logic       reset,
    input  logic [4:0] live_note,
    input  logic [4:0] song_note,
    input  logic       song_active,
    input  logic       channel_sel,
    input  logic       mute,
    output logic [4:0] tone_note,
    output logic [1:0] owner,
    output logic       note_strobe,
    output logic       busy
);
    localparam int MAXC = GAP_CYCLES > MIN_PLAY_CYCLES ? GAP_CYCLES : MIN_PLAY_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    r_live, r_song;
    logic          r_act, r_sel, r_mute;
    logic          live_req, song_req, w_live, w_song;
    logic [1:0]    w_owner;
    logic [4:0]    w_note;
    always_comb begin
        live_req = r_live <= NOTE_MAX;
        song_req = r_act && (r_song <= NOTE_MAX);
        w_live   = live_req && (r_sel || !song_req);
        w_song   = song_req && !w_live;
        w_owner  = w_live ? OWNER_LIVE : (w_song ? OWNER_SONG : OWNER_NONE);
        w_note   = w_live ? r_live : r_song;
    end
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            r_live      <= NOTE_REST;
            r_song      <= NOTE_REST;
            r_act       <= 1'b0;
            r_sel       <= 1'b0;
            r_mute      <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            tone_note   <= NOTE_REST;
            owner       <= OWNER_NONE;
            note_strobe <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_live      <= live_note;
            r_song      <= song_note;
            r_act       <= song_active;
            r_sel       <= channel_sel;
            r_mute      <= mute;
            note_strobe <= 1'b0;
            if (r_mute) begin
                state     <= IDLE;
                cnt       <= '0;
                tone_note <= NOTE_REST;
                owner     <= OWNER_NONE;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (w_owner != OWNER_NONE) begin
                        state       <= PLAY;
                        cnt         <= CW'(MIN_PLAY_CYCLES - 1);
                        tone_note   <= w_note;
                        owner       <= w_owner;
                        note_strobe <= 1'b1;
                        busy        <= 1'b1;
                    end
                    // tone_note doubles as the latched note while playing
                    PLAY: if (cnt != '0) cnt <= cnt - CW'(1);
                    else if (w_owner != owner || w_note != tone_note) begin
                        state     <= GAP;
                        cnt       <= CW'(GAP_CYCLES - 1);
                        tone_note <= NOTE_REST;
                        owner     <= OWNER_NONE;
                    end
                    GAP: if (cnt != '0) cnt <= cnt - CW'(1);
                    else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tone_arbiter.sv
// tb_tone_arbiter: directed scoreboard bench for tone_arbiter with GAP=4, MIN_PLAY=8
module tb_tone_arbiter;
    logic       inclk, reset, song_active, channel_sel, mute, note_strobe, busy;
    logic [4:0] live_note, song_note, tone_note;
    logic [1:0] owner;
    typedef struct {
        logic [4:0] t;
        logic [1:0] o;
        logic       s;
        logic       b;
        string      tag;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int fails  = 0;

    tone_arbiter #(.GAP_CYCLES(4), .MIN_PLAY_CYCLES(8)) dut (
        .inclk(inclk), .reset(reset), .live_note(live_note), .song_note(song_note),
        .song_active(song_active), .channel_sel(channel_sel), .mute(mute),
        .tone_note(tone_note), .owner(owner), .note_strobe(note_strobe), .busy(busy)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    task automatic push(input int n, input logic [4:0] t, input logic [1:0] o,
                        input logic s, input logic b, input string tag);
        repeat (n) sb.push_back('{t, o, s, b, tag});
    endtask

    task automatic check_now();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL underflow: observed empty scoreboard, expected an entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert ({tone_note, owner, note_strobe, busy} === {e.t, e.o, e.s, e.b}) else begin
                fails++;
                $error("FAIL %s: observed tone=%0d owner=%0d strobe=%0b busy=%0b expected tone=%0d owner=%0d strobe=%0b busy=%0b",
                       e.tag, tone_note, owner, note_strobe, busy, e.t, e.o, e.s, e.b);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge inclk);
            #1;
            check_now();
        end
    endtask

    task automatic idle_inputs();
        live_note = 5'd21; song_note = 5'd21; song_active = 1'b0;
        channel_sel = 1'b1; mute = 1'b0;
    endtask

    task automatic rst_pulse(input string tag);
        idle_inputs();
        reset = 1'b1;
        #1;
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, tag);
        check_now();
        reset = 1'b0;
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, {tag, "_idle"});
        run(1);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, "reset");
        check_now();
        push(2, 5'd21, 2'd0, 1'b0, 1'b0, "reset_held");
        run(2);
        reset = 1'b0;

        // single live note, held: one strobe only
        live_note = 5'd7;
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, "s1_latency");
        push(1, 5'd7, 2'd1, 1'b1, 1'b1, "s1_start");
        push(20, 5'd7, 2'd1, 1'b0, 1'b1, "s1_hold");
        run(22);
        live_note = 5'd21;
        push(1, 5'd7, 2'd1, 1'b0, 1'b1, "s1_release");
        push(4, 5'd21, 2'd0, 1'b0, 1'b1, "s1_gap");
        push(2, 5'd21, 2'd0, 1'b0, 1'b0, "s1_idle");
        run(7);

        // short press still lasts MIN_PLAY cycles
        live_note = 5'd7;
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, "s2_latency");
        push(1, 5'd7, 2'd1, 1'b1, 1'b1, "s2_start");
        push(1, 5'd7, 2'd1, 1'b0, 1'b1, "s2_play");
        run(3);
        live_note = 5'd21;
        push(6, 5'd7, 2'd1, 1'b0, 1'b1, "s2_min_play");
        push(4, 5'd21, 2'd0, 1'b0, 1'b1, "s2_gap");
        push(2, 5'd21, 2'd0, 1'b0, 1'b0, "s2_idle");
        run(12);

        // note change 7 -> 9 re-articulates through gap + idle
        live_note = 5'd7;
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, "s3_latency");
        push(1, 5'd7, 2'd1, 1'b1, 1'b1, "s3_start");
        push(8, 5'd7, 2'd1, 1'b0, 1'b1, "s3_play");
        run(10);
        live_note = 5'd9;
        push(1, 5'd7, 2'd1, 1'b0, 1'b1, "s3_pre_check");
        push(4, 5'd21, 2'd0, 1'b0, 1'b1, "s3_gap");
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, "s3_idle");
        push(1, 5'd9, 2'd1, 1'b1, 1'b1, "s3_new_start");
        push(2, 5'd9, 2'd1, 1'b0, 1'b1, "s3_new_play");
        run(9);
        rst_pulse("s3_reset");

        // song priority, then fall back to live
        channel_sel = 1'b0; song_active = 1'b1; song_note = 5'd14; live_note = 5'd3;
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, "s4_latency");
        push(1, 5'd14, 2'd2, 1'b1, 1'b1, "s4_song_start");
        push(2, 5'd14, 2'd2, 1'b0, 1'b1, "s4_song_play");
        run(4);
        song_active = 1'b0;
        push(5, 5'd14, 2'd2, 1'b0, 1'b1, "s4_song_min");
        push(4, 5'd21, 2'd0, 1'b0, 1'b1, "s4_gap");
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, "s4_idle");
        push(1, 5'd3, 2'd1, 1'b1, 1'b1, "s4_live_start");
        push(1, 5'd3, 2'd1, 1'b0, 1'b1, "s4_live_play");
        run(12);
        rst_pulse("s4_reset");

        // mute during play
        live_note = 5'd12;
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, "s5_latency");
        push(1, 5'd12, 2'd1, 1'b1, 1'b1, "s5_start");
        push(1, 5'd12, 2'd1, 1'b0, 1'b1, "s5_play");
        run(3);
        mute = 1'b1;
        push(1, 5'd12, 2'd1, 1'b0, 1'b1, "s5_mute_latency");
        push(3, 5'd21, 2'd0, 1'b0, 1'b0, "s5_muted");
        run(4);
        mute = 1'b0;
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, "s5_unmute_latency");
        push(1, 5'd12, 2'd1, 1'b1, 1'b1, "s5_resume");
        push(1, 5'd12, 2'd1, 1'b0, 1'b1, "s5_resume_play");
        run(3);
        rst_pulse("s5_reset");

        // invalid codes behave as rest
        live_note = 5'd25;
        push(4, 5'd21, 2'd0, 1'b0, 1'b0, "s6_live_invalid");
        run(4);
        song_active = 1'b1; song_note = 5'd22; live_note = 5'd31;
        push(4, 5'd21, 2'd0, 1'b0, 1'b0, "s6_both_invalid");
        run(4);

        // NOTE_MAX is valid; asynchronous reset mid-play
        song_active = 1'b0; live_note = 5'd20;
        push(1, 5'd21, 2'd0, 1'b0, 1'b0, "s7_latency");
        push(1, 5'd20, 2'd1, 1'b1, 1'b1, "s7_max_start");
        push(2, 5'd20, 2'd1, 1'b0, 1'b1, "s7_max_play");
        run(4);
        rst_pulse("s7_async_reset");

        checks++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL leftover: observed %0d entries, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
